// File: rtl/pxie_rx_pkg.sv
// rtl/pxie_rx_pkg.sv - shared constants, FSM encoding and opcode decode for the PXIe rx command path
package pxie_rx_pkg;

    localparam logic [15:0] SYNC_WORD    = 16'hEB9C;
    localparam logic [15:0] OP_RST       = 16'h0001;
    localparam logic [15:0] OP_TRIG      = 16'h0002;
    localparam logic [15:0] OP_TRIG_NUM  = 16'h0003;
    localparam logic [15:0] OP_TRIG_STEP = 16'h0004;
    localparam logic [15:0] OP_RUN       = 16'h1100;
    localparam logic [15:0] OP_C2H       = 16'h1010;
    localparam logic [11:0] OP_BURST_HI  = 12'h100;
    localparam logic [11:0] OP_SETUP_HI  = 12'h200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_PULSE,
        ST_BURST,
        ST_DONE
    } state_t;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_RST,
        CMD_TRIG,
        CMD_RUN,
        CMD_TNUM,
        CMD_TSTEP,
        CMD_SETUP,
        CMD_BURST,
        CMD_C2H,
        CMD_BAD
    } cmd_t;

    // Channel opcodes carry the channel in the low nibble; out-of-range channels are errors.
    function automatic cmd_t decode_op(input logic [15:0] op, input int nch);
        cmd_t c;
        c = CMD_BAD;
        if (op == OP_RST)            c = CMD_RST;
        else if (op == OP_TRIG)      c = CMD_TRIG;
        else if (op == OP_RUN)       c = CMD_RUN;
        else if (op == OP_TRIG_NUM)  c = CMD_TNUM;
        else if (op == OP_TRIG_STEP) c = CMD_TSTEP;
        else if (op == OP_C2H)       c = CMD_C2H;
        else if (op[15:4] == OP_SETUP_HI && int'(op[3:0]) < nch) c = CMD_SETUP;
        else if (op[15:4] == OP_BURST_HI && int'(op[3:0]) < nch) c = CMD_BURST;
        return c;
    endfunction

endpackage

// File: rtl/pxie_rx_cmd_decoder_if.sv
// rtl/pxie_rx_cmd_decoder_if.sv - PXIe rx word stream in and RAM write port out
interface pxie_rx_cmd_decoder_if #(
    parameter int DATA_W = 128,
    parameter int NCH    = 4
);
    logic [DATA_W-1:0] I_PXIE_DATA;
    logic              I_PXIE_DATA_VLD;
    logic [NCH-1:0]    O_wr_en;
    logic [31:0]       O_wr_addr;
    logic [DATA_W-1:0] O_wr_data;

    modport master (
        output I_PXIE_DATA, I_PXIE_DATA_VLD,
        input  O_wr_en, O_wr_addr, O_wr_data
    );

    modport slave (
        input  I_PXIE_DATA, I_PXIE_DATA_VLD,
        output O_wr_en, O_wr_addr, O_wr_data
    );
endinterface

// File: rtl/pxie_pulse_stretch.sv
// rtl/pxie_pulse_stretch.sv - turns a one-clock start into a PULSE_CYC-clock high level
module pxie_pulse_stretch #(
    parameter int PULSE_CYC = 50
) (
    input  logic I_PXIE_CLK,
    input  logic I_Rst_n,
    input  logic start,
    output logic level
);
    localparam int CW = $clog2(PULSE_CYC + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= CW'(PULSE_CYC);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign level = (cnt_q != '0);
endmodule

// File: rtl/pxie_rx_cmd_decoder.sv
// rtl/pxie_rx_cmd_decoder.sv - decodes EB9C command words into pulses, config registers, RAM bursts and c2h requests
module pxie_rx_cmd_decoder
    import pxie_rx_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int NCH         = 4,
    parameter int PULSE_CYC   = 50,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ADDR_STEP   = 2
) (
    input  logic                   I_PXIE_CLK,
    input  logic                   I_Rst_n,
    pxie_rx_cmd_decoder_if.slave   rx,
    output logic                   O_Rst,
    output logic                   O_Trig,
    output logic                   O_Run,
    output logic [31:0]            O_Trig_Num,
    output logic [31:0]            O_Trig_Step,
    output logic [15:0]            O_c2h_addr,
    output logic [15:0]            O_c2h_len,
    output logic                   O_c2h_en,
    output logic                   O_busy,
    output logic [15:0]            O_err_cnt,
    output logic                   O_err
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state, state_nxt;
    cmd_t              head_cmd;
    logic [DATA_W-1:0] data;
    logic              vld, is_cmd;
    logic [15:0]       op, arg;
    logic [31:0]       addr;
    logic [CH_W-1:0]   op_ch, burst_ch;
    logic [31:0]       base_q [NCH];
    logic [15:0]       cnt_q  [NCH];
    logic [15:0]       remain_q;
    logic [TO_W-1:0]   idle_q;
    logic [NCH-1:0]    ch_onehot;
    logic              burst_word, burst_last, burst_timeout, err_evt;
    logic              start_rst, start_trig, start_run;

    assign data   = rx.I_PXIE_DATA;
    assign vld    = rx.I_PXIE_DATA_VLD;
    assign op     = data[15:0];
    assign arg    = data[47:32];
    assign addr   = data[95:64];
    assign op_ch  = op[CH_W-1:0];
    assign is_cmd = vld && (data[63:48] == SYNC_WORD);
    assign O_busy = (state == ST_PULSE) || (state == ST_BURST) || (state == ST_DONE);

    always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  state_nxt = ST_HEAD;
            ST_HEAD: begin
                case (head_cmd)
                    CMD_RST, CMD_TRIG, CMD_RUN: state_nxt = ST_PULSE;
                    CMD_BURST: state_nxt = (cnt_q[op_ch] == '0) ? ST_DONE : ST_BURST;
                    CMD_C2H:   state_nxt = ST_DONE;
                    default:   state_nxt = ST_HEAD;
                endcase
            end
            ST_PULSE: if (!(O_Rst || O_Trig || O_Run)) state_nxt = ST_DONE;
            ST_BURST: if (burst_last || burst_timeout) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_HEAD;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Commands are only decoded in HEAD; PULSE and DONE silently drop incoming words.
    always_comb begin
        head_cmd      = CMD_NONE;
        if (state == ST_HEAD && is_cmd) head_cmd = decode_op(op, NCH);
        start_rst     = (head_cmd == CMD_RST);
        start_trig    = (head_cmd == CMD_TRIG);
        start_run     = (head_cmd == CMD_RUN);
        burst_word    = (state == ST_BURST) && vld;
        burst_last    = burst_word && (remain_q == 16'd1);
        burst_timeout = (state == ST_BURST) && !vld && (idle_q == TO_W'(TIMEOUT_CYC - 1));
        err_evt       = (head_cmd == CMD_BAD) || burst_timeout;
        ch_onehot     = '0;
        ch_onehot[burst_ch] = 1'b1;
    end

    always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            rx.O_wr_en   <= '0;
            rx.O_wr_addr <= '0;
            rx.O_wr_data <= '0;
            O_Trig_Num   <= '0;
            O_Trig_Step  <= '0;
            O_c2h_addr   <= '0;
            O_c2h_len    <= '0;
            O_c2h_en     <= 1'b0;
            O_err_cnt    <= '0;
            O_err        <= 1'b0;
            burst_ch     <= '0;
            remain_q     <= '0;
            idle_q       <= '0;
            for (int i = 0; i < NCH; i++) begin
                base_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            rx.O_wr_en <= '0;
            O_c2h_en   <= 1'b0;
            O_err      <= 1'b0;
            if (head_cmd == CMD_TNUM)  O_Trig_Num  <= data[31:0];
            if (head_cmd == CMD_TSTEP) O_Trig_Step <= data[31:0];
            if (head_cmd == CMD_SETUP) begin
                base_q[op_ch] <= addr;
                cnt_q[op_ch]  <= arg;
            end
            if (head_cmd == CMD_BURST) begin
                burst_ch <= op_ch;
                remain_q <= cnt_q[op_ch];
                idle_q   <= '0;
            end
            // The stored base walks with the burst so a repeat burst continues where this one stopped.
            if (burst_word) begin
                rx.O_wr_en       <= ch_onehot;
                rx.O_wr_addr     <= base_q[burst_ch];
                rx.O_wr_data     <= data;
                base_q[burst_ch] <= base_q[burst_ch] + 32'(ADDR_STEP);
                remain_q         <= remain_q - 16'd1;
                idle_q           <= '0;
            end else if (state == ST_BURST) begin
                idle_q <= idle_q + TO_W'(1);
            end
            if (head_cmd == CMD_C2H) begin
                O_c2h_addr <= data[79:64];
                O_c2h_len  <= arg;
                O_c2h_en   <= 1'b1;
            end
            if (err_evt) begin
                O_err <= 1'b1;
                if (O_err_cnt != 16'hFFFF) O_err_cnt <= O_err_cnt + 16'd1;
            end
        end
    end

    pxie_pulse_stretch #(.PULSE_CYC(PULSE_CYC)) u_rst_stretch (
        .I_PXIE_CLK (I_PXIE_CLK),
        .I_Rst_n    (I_Rst_n),
        .start      (start_rst),
        .level      (O_Rst)
    );

    pxie_pulse_stretch #(.PULSE_CYC(PULSE_CYC)) u_trig_stretch (
        .I_PXIE_CLK (I_PXIE_CLK),
        .I_Rst_n    (I_Rst_n),
        .start      (start_trig),
        .level      (O_Trig)
    );

    pxie_pulse_stretch #(.PULSE_CYC(PULSE_CYC)) u_run_stretch (
        .I_PXIE_CLK (I_PXIE_CLK),
        .I_Rst_n    (I_Rst_n),
        .start      (start_run),
        .level      (O_Run)
    );
endmodule

// File: tb/tb_pxie_rx_cmd_decoder.sv
// tb/tb_pxie_rx_cmd_decoder.sv - randomized self-checking bench for pxie_rx_cmd_decoder
module tb_pxie_rx_cmd_decoder;
    localparam int DATA_W      = 128;
    localparam int NCH         = 4;
    localparam int PULSE_CYC   = 50;
    localparam int TIMEOUT_CYC = 1024;
    localparam int ADDR_STEP   = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        O_Rst, O_Trig, O_Run, O_c2h_en, O_busy, O_err;
    logic [31:0] O_Trig_Num, O_Trig_Step;
    logic [15:0] O_c2h_addr, O_c2h_len, O_err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_base [NCH];
    logic [15:0] m_cnt  [NCH];
    int          m_err  = 0;
    logic [31:0] m_tnum = '0;
    logic [31:0] m_tstep = '0;

    pxie_rx_cmd_decoder_if #(.DATA_W(DATA_W), .NCH(NCH)) rx ();

    pxie_rx_cmd_decoder #(
        .DATA_W(DATA_W), .NCH(NCH), .PULSE_CYC(PULSE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .ADDR_STEP(ADDR_STEP)
    ) dut (
        .I_PXIE_CLK  (clk),
        .I_Rst_n     (rst_n),
        .rx          (rx),
        .O_Rst       (O_Rst),
        .O_Trig      (O_Trig),
        .O_Run       (O_Run),
        .O_Trig_Num  (O_Trig_Num),
        .O_Trig_Step (O_Trig_Step),
        .O_c2h_addr  (O_c2h_addr),
        .O_c2h_len   (O_c2h_len),
        .O_c2h_en    (O_c2h_en),
        .O_busy      (O_busy),
        .O_err_cnt   (O_err_cnt),
        .O_err       (O_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk_cmd(input logic [15:0] op, input logic [15:0] arg,
                                                 input logic [31:0] addr, input logic [15:0] hi);
        logic [DATA_W-1:0] w;
        w = '0;
        w[15:0]  = op;
        w[31:16] = hi;
        w[47:32] = arg;
        w[63:48] = 16'hEB9C;
        w[95:64] = addr;
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit op_defined(input int o);
        if (o == 1 || o == 2 || o == 3 || o == 4 || o == 'h1100 || o == 'h1010) return 1'b1;
        if ((o / 16 == 'h100 || o / 16 == 'h200) && (o % 16) < NCH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic lvl(input int k);
        return (k == 0) ? O_Rst : (k == 1) ? O_Trig : O_Run;
    endfunction

    task automatic cycle(input logic [DATA_W-1:0] d, input logic v);
        rx.I_PXIE_DATA     = d;
        rx.I_PXIE_DATA_VLD = v;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_base[i] = '0;
            m_cnt[i]  = '0;
        end
        m_err   = 0;
        m_tnum  = '0;
        m_tstep = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        n_checks++;
        if ({O_Rst, O_Trig, O_Run, O_busy, O_err, O_c2h_en} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {O_Rst, O_Trig, O_Run, O_busy, O_err, O_c2h_en});
        else n_pass++;
        n_checks++;
        if (rx.O_wr_en !== '0 || rx.O_wr_addr !== '0 || rx.O_wr_data !== '0)
            $display("FAIL reset_wr: got en=%b addr=%h want 0", rx.O_wr_en, rx.O_wr_addr);
        else n_pass++;
        n_checks++;
        if (O_Trig_Num !== '0 || O_Trig_Step !== '0 || O_c2h_addr !== '0 || O_c2h_len !== '0 || O_err_cnt !== '0)
            $display("FAIL reset_regs: got num=%h step=%h errcnt=%h want 0", O_Trig_Num, O_Trig_Step, O_err_cnt);
        else n_pass++;
        rst_n = 1'b1;
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        n_checks++;
        if (O_busy !== 1'b0) $display("FAIL reset_head_busy: got %b want 0", O_busy);
        else n_pass++;
    endtask

    task automatic test_pulse();
        logic [15:0] ops [3];
        ops[0] = 16'h0001;
        ops[1] = 16'h0002;
        ops[2] = 16'h1100;
        for (int k = 0; k < 3; k++) begin
            int hi, busy_bad, other_bad, wait_n;
            hi = 0; busy_bad = 0; other_bad = 0; wait_n = 0;
            cycle(mk_cmd(ops[k], 16'h0, 32'h0, 16'h0), 1'b1);
            while (lvl(k) === 1'b1 && hi < PULSE_CYC + 20) begin
                hi++;
                if (O_busy !== 1'b1) busy_bad++;
                if (lvl((k + 1) % 3) !== 1'b0 || lvl((k + 2) % 3) !== 1'b0) other_bad++;
                if (hi == 3) cycle(mk_cmd(16'h0003, 16'h0, 32'h0, 16'($urandom)), 1'b1);
                else         cycle(rand_word(), 1'(hi % 2));
            end
            n_checks++;
            if (hi != PULSE_CYC) $display("FAIL pulse_len[%0d]: got %0d clocks want %0d", k, hi, PULSE_CYC);
            else n_pass++;
            n_checks++;
            if (busy_bad != 0 || other_bad != 0)
                $display("FAIL pulse_busy_other[%0d]: got %0d/%0d bad clocks want 0/0", k, busy_bad, other_bad);
            else n_pass++;
            while (O_busy === 1'b1 && wait_n < 5) begin
                cycle('0, 1'b0);
                wait_n++;
            end
            n_checks++;
            if (O_busy !== 1'b0) $display("FAIL pulse_done[%0d]: got busy %b want 0", k, O_busy);
            else n_pass++;
            n_checks++;
            if (O_Trig_Num !== m_tnum) $display("FAIL pulse_ignore[%0d]: got %h want %h", k, O_Trig_Num, m_tnum);
            else n_pass++;
        end
    endtask

    task automatic test_trig_cfg();
        for (int i = 0; i < 4; i++) begin
            logic [15:0] hi, op;
            hi = 16'($urandom);
            op = (i % 2 == 0) ? 16'h0003 : 16'h0004;
            cycle(mk_cmd(op, 16'($urandom), $urandom, hi), 1'b1);
            if (op == 16'h0003) m_tnum = {hi, op};
            else                m_tstep = {hi, op};
            n_checks++;
            if (O_Trig_Num !== m_tnum || O_Trig_Step !== m_tstep || O_busy !== 1'b0)
                $display("FAIL trig_cfg[%0d]: got num=%h step=%h busy=%b want num=%h step=%h busy=0",
                         i, O_Trig_Num, O_Trig_Step, O_busy, m_tnum, m_tstep);
            else n_pass++;
        end
    endtask

    task automatic test_bad_op();
        logic [15:0] fixed [4];
        logic [DATA_W-1:0] w;
        fixed[0] = 16'h1007;
        fixed[1] = 16'h2004;
        fixed[2] = 16'h0000;
        fixed[3] = 16'h1104;
        for (int i = 0; i < 8; i++) begin
            int o;
            if (i < 4) o = int'(fixed[i]);
            else begin
                o = int'($urandom_range(0, 65535));
                while (op_defined(o)) o = int'($urandom_range(0, 65535));
            end
            cycle(mk_cmd(16'(o), 16'($urandom), $urandom, 16'h0), 1'b1);
            m_err++;
            n_checks++;
            if (O_err !== 1'b1 || O_err_cnt !== 16'(m_err) || rx.O_wr_en !== '0 || O_busy !== 1'b0)
                $display("FAIL bad_op[%h]: got err=%b cnt=%0d wr_en=%b busy=%b want 1/%0d/0/0",
                         16'(o), O_err, O_err_cnt, rx.O_wr_en, O_busy, m_err);
            else n_pass++;
            cycle('0, 1'b0);
            n_checks++;
            if (O_err !== 1'b0) $display("FAIL bad_op_strobe[%h]: got err %b want 0", 16'(o), O_err);
            else n_pass++;
        end
        w = rand_word();
        w[63:48] = 16'h1234;
        w[15:0]  = 16'h1007;
        cycle(w, 1'b1);
        n_checks++;
        if (O_err !== 1'b0 || O_err_cnt !== 16'(m_err))
            $display("FAIL non_sync: got err=%b cnt=%0d want 0/%0d", O_err, O_err_cnt, m_err);
        else n_pass++;
    endtask

    task automatic test_c2h();
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a, l;
            a = (i == 0) ? 16'h0040 : 16'($urandom);
            l = (i == 0) ? 16'h0010 : 16'($urandom);
            cycle(mk_cmd(16'h1010, l, {16'($urandom), a}, 16'h0), 1'b1);
            n_checks++;
            if (O_c2h_en !== 1'b1 || O_c2h_addr !== a || O_c2h_len !== l || O_busy !== 1'b1)
                $display("FAIL c2h[%0d]: got en=%b addr=%h len=%h busy=%b want 1/%h/%h/1",
                         i, O_c2h_en, O_c2h_addr, O_c2h_len, O_busy, a, l);
            else n_pass++;
            cycle(mk_cmd(16'h1010, 16'h0, 32'h0, 16'h0), 1'b1);
            n_checks++;
            if (O_c2h_en !== 1'b0 || O_c2h_addr !== a || O_busy !== 1'b0)
                $display("FAIL c2h_once[%0d]: got en=%b addr=%h busy=%b want 0/%h/0", i, O_c2h_en, O_c2h_addr, O_busy, a);
            else n_pass++;
        end
    endtask

    task automatic test_burst();
        for (int it = 0; it < 10; it++) begin
            int ch, cnt, k;
            bit setup;
            logic [31:0] base, exp_addr;
            logic [NCH-1:0] exp_en;
            logic [DATA_W-1:0] w;
            if (it == 0) begin
                ch = 2; base = 32'h100; cnt = 3; setup = 1'b1;
            end else if (it == 9) begin
                ch = int'($urandom_range(0, NCH - 1)); base = $urandom; cnt = 0; setup = 1'b1;
            end else begin
                ch = int'($urandom_range(0, NCH - 1)); base = $urandom; cnt = int'($urandom_range(1, 6));
                setup = (m_cnt[ch] == 16'h0) || ($urandom_range(0, 2) != 0);
            end
            if (setup) begin
                cycle(mk_cmd(16'(16'h2000 + ch), 16'(cnt), base, 16'h0), 1'b1);
                m_base[ch] = base;
                m_cnt[ch]  = 16'(cnt);
            end
            cnt = int'(m_cnt[ch]);
            exp_en = '0;
            exp_en[ch] = 1'b1;
            cycle(mk_cmd(16'(16'h1000 + ch), 16'h0, 32'h0, 16'h0), 1'b1);
            n_checks++;
            if (O_busy !== 1'b1 || rx.O_wr_en !== '0)
                $display("FAIL burst_start[%0d]: got busy=%b wr_en=%b want 1/0", it, O_busy, rx.O_wr_en);
            else n_pass++;
            k = 0;
            while (k < cnt) begin
                if (it != 0 && $urandom_range(0, 3) == 0) begin
                    cycle(rand_word(), 1'b0);
                    n_checks++;
                    if (rx.O_wr_en !== '0) $display("FAIL burst_gap[%0d]: got wr_en=%b want 0", it, rx.O_wr_en);
                    else n_pass++;
                end else begin
                    w = rand_word();
                    cycle(w, 1'b1);
                    exp_addr = m_base[ch] + 32'(k * ADDR_STEP);
                    n_checks++;
                    if (rx.O_wr_en !== exp_en || rx.O_wr_addr !== exp_addr || rx.O_wr_data !== w)
                        $display("FAIL burst_wr[%0d.%0d]: got en=%b addr=%h data=%h want en=%b addr=%h data=%h",
                                 it, k, rx.O_wr_en, rx.O_wr_addr, rx.O_wr_data, exp_en, exp_addr, w);
                    else n_pass++;
                    k++;
                end
            end
            m_base[ch] = m_base[ch] + 32'(cnt * ADDR_STEP);
            cycle(mk_cmd(16'h0005, 16'h0, 32'h0, 16'h0), 1'b1);
            n_checks++;
            if (rx.O_wr_en !== '0 || O_err !== 1'b0 || O_err_cnt !== 16'(m_err) || O_busy !== 1'b0)
                $display("FAIL burst_end[%0d]: got wr_en=%b err=%b cnt=%0d busy=%b want 0/0/%0d/0",
                         it, rx.O_wr_en, O_err, O_err_cnt, O_busy, m_err);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int first_err, wait_n;
        logic [31:0] base, exp_addr;
        logic [DATA_W-1:0] w;
        base = $urandom;
        cycle(mk_cmd(16'h2001, 16'd4, base, 16'h0), 1'b1);
        m_base[1] = base;
        m_cnt[1]  = 16'd4;
        cycle(mk_cmd(16'h1001, 16'h0, 32'h0, 16'h0), 1'b1);
        for (int k = 0; k < 2; k++) begin
            w = rand_word();
            cycle(w, 1'b1);
            exp_addr = base + 32'(k * ADDR_STEP);
            n_checks++;
            if (rx.O_wr_en !== 4'b0010 || rx.O_wr_addr !== exp_addr || rx.O_wr_data !== w)
                $display("FAIL timeout_wr[%0d]: got en=%b addr=%h want 0010/%h", k, rx.O_wr_en, rx.O_wr_addr, exp_addr);
            else n_pass++;
        end
        m_base[1] = base + 32'(2 * ADDR_STEP);
        first_err = 0;
        for (int i = 1; i <= TIMEOUT_CYC + 50; i++) begin
            cycle('0, 1'b0);
            if (O_err === 1'b1) begin
                first_err = i;
                break;
            end
        end
        m_err++;
        n_checks++;
        if (first_err != TIMEOUT_CYC)
            $display("FAIL timeout_len: got err after %0d idle clocks want %0d", first_err, TIMEOUT_CYC);
        else n_pass++;
        n_checks++;
        if (O_err_cnt !== 16'(m_err)) $display("FAIL timeout_cnt: got %0d want %0d", O_err_cnt, m_err);
        else n_pass++;
        wait_n = 0;
        while (O_busy === 1'b1 && wait_n < 4) begin
            cycle('0, 1'b0);
            wait_n++;
        end
        n_checks++;
        if (O_busy !== 1'b0 || O_err !== 1'b0)
            $display("FAIL timeout_head: got busy=%b err=%b want 0/0", O_busy, O_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] base;
        base = $urandom;
        cycle(mk_cmd(16'h2000, 16'd5, base, 16'h0), 1'b1);
        cycle(mk_cmd(16'h1000, 16'h0, 32'h0, 16'h0), 1'b1);
        cycle(rand_word(), 1'b1);
        cycle(rand_word(), 1'b1);
        n_checks++;
        if (rx.O_wr_en !== 4'b0001 || rx.O_wr_addr !== base + 32'(ADDR_STEP))
            $display("FAIL rst_mid_pre: got en=%b addr=%h want 0001/%h", rx.O_wr_en, rx.O_wr_addr, base + 32'(ADDR_STEP));
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (rx.O_wr_en !== '0 || rx.O_wr_addr !== '0 || O_busy !== 1'b0 || O_err_cnt !== '0 || O_Trig_Num !== '0)
            $display("FAIL rst_mid_burst: got en=%b addr=%h busy=%b cnt=%0d num=%h want all 0",
                     rx.O_wr_en, rx.O_wr_addr, O_busy, O_err_cnt, O_Trig_Num);
        else n_pass++;
        rst_n = 1'b1;
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        cycle(mk_cmd(16'h1000, 16'h0, 32'h0, 16'h0), 1'b1);
        cycle(rand_word(), 1'b1);
        n_checks++;
        if (rx.O_wr_en !== '0 || rx.O_wr_addr !== '0 || O_busy !== 1'b0)
            $display("FAIL rst_no_resume: got en=%b addr=%h busy=%b want 0/0/0", rx.O_wr_en, rx.O_wr_addr, O_busy);
        else n_pass++;
        cycle(mk_cmd(16'h1100, 16'h0, 32'h0, 16'h0), 1'b1);
        for (int i = 0; i < 10; i++) cycle('0, 1'b0);
        n_checks++;
        if (O_Run !== 1'b1) $display("FAIL rst_pulse_pre: got run=%b want 1", O_Run);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (O_Run !== 1'b0 || O_busy !== 1'b0) $display("FAIL rst_mid_pulse: got run=%b busy=%b want 0/0", O_Run, O_busy);
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle('0, 1'b0);
        n_checks++;
        if (O_Run !== 1'b0 || O_busy !== 1'b0) $display("FAIL rst_pulse_resume: got run=%b busy=%b want 0/0", O_Run, O_busy);
        else n_pass++;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rx.I_PXIE_DATA     = '0;
        rx.I_PXIE_DATA_VLD = 1'b0;
        test_reset();
        test_pulse();
        test_trig_cfg();
        test_bad_op();
        test_c2h();
        test_burst();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pxie_rx_cmd_decoder.md
PXIE_RX_CMD_DECODER -- requirements
Module: pxie_rx_cmd_decoder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, meaning PXIe data word width (min 128).
REQ-002 The block SHALL have parameter NCH, default 4, meaning number of RAM write channels (1..16).
REQ-003 The block SHALL have parameter PULSE_CYC, default 50, meaning high duration in clocks of stretched Rst/Trig/Run outputs.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1024, meaning maximum idle clocks tolerated inside a burst.
REQ-005 The block SHALL have parameter ADDR_STEP, default 2, meaning write-address increment per data word.
REQ-006 The block SHALL have ports: I_PXIE_CLK  in  1  clock; I_Rst_n  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have ports: I_PXIE_DATA  in  DATA_W  data word; I_PXIE_DATA_VLD  in  1  word valid.
REQ-008 The block SHALL have ports: O_Rst, O_Trig, O_Run  out  1 each  stretched pulses.
REQ-009 The block SHALL have ports: O_Trig_Num, O_Trig_Step  out  32 each  trigger configuration.
REQ-010 The block SHALL have ports: O_wr_en  out  NCH  one-hot write strobe; O_wr_addr  out  32; O_wr_data  out  DATA_W.
REQ-011 The block SHALL have ports: O_c2h_addr, O_c2h_len  out  16 each; O_c2h_en  out  1  one-cycle read request.
REQ-012 The block SHALL have ports: O_busy  out  1  FSM not in HEAD; O_err_cnt  out  16  saturating error count; O_err  out  1  one-cycle error strobe.

Function
REQ-013 A command word SHALL be recognised only when VLD=1 and DATA[63:48]=16'hEB9C; opcode=DATA[15:0], arg=DATA[47:32], addr=DATA[95:64].
REQ-014 The FSM SHALL have states IDLE, HEAD, PULSE, BURST, DONE; IDLE->HEAD unconditionally; DONE->HEAD unconditionally.
REQ-015 Opcode 0x0001/0x0002/0x1100 SHALL enter PULSE and start a PULSE_CYC-clock high window on O_Rst/O_Trig/O_Run respectively, beginning the clock after the header; PULSE->DONE when window ends.
REQ-016 Opcode 0x0003/0x0004 SHALL load DATA[31:0] into O_Trig_Num/O_Trig_Step the clock after the header; FSM stays in HEAD.
REQ-017 Opcode 0x2000+ch (ch<NCH) SHALL load channel ch base address=addr and word count=arg; stays in HEAD.
REQ-018 Opcode 0x1000+ch (ch<NCH) SHALL enter BURST for channel ch using its stored base/count; count=0 SHALL go directly to DONE with no write.
REQ-019 In BURST each VLD word SHALL produce, one clock later, O_wr_en[ch]=1, O_wr_data=word, O_wr_addr=base+k*ADDR_STEP (k=0..count-1); the stored base SHALL advance accordingly; non-VLD clocks drive O_wr_en=0.
REQ-020 BURST SHALL exit to DONE on the clock the count-th word is accepted; words beyond count are not consumed by the burst.
REQ-021 If VLD stays low TIMEOUT_CYC consecutive clocks in BURST, the block SHALL pulse O_err, increment O_err_cnt, and go to DONE.
REQ-022 Opcode 0x1010 SHALL latch O_c2h_addr=DATA[15:0]... no: O_c2h_addr=DATA[79:64], O_c2h_len=arg and pulse O_c2h_en for exactly one clock, then DONE.
REQ-023 Any EB9C word with undefined opcode or ch>=NCH SHALL pulse O_err and increment O_err_cnt; FSM stays in HEAD.
REQ-024 O_err_cnt SHALL saturate at 16'hFFFF.
REQ-025 Words arriving in PULSE or DONE SHALL be ignored.

Reset
REQ-026 On I_Rst_n low, FSM SHALL go to IDLE and all outputs, counters, stored bases/counts SHALL be 0 asynchronously.
REQ-027 Reset mid-burst or mid-pulse SHALL drop O_wr_en and stretched pulses within the same assertion; no resumption after release.

Structure
REQ-028 Sync word, opcode constants and FSM state encoding SHALL live in shared package pxie_rx_pkg.
REQ-029 Pulse stretching SHALL be one reusable sub-module pxie_pulse_stretch (start in, PULSE_CYC param, level out), instantiated three times.

Verification
REQ-030 Header 0xEB9C/op 0x0001 -> O_Rst high exactly 50 clocks starting 1 clock later; O_busy high until DONE.
REQ-031 Setup op 0x2002 addr=0x100 arg=3, then op 0x1002 + 3 VLD words -> O_wr_en=4'b0100 thrice, addr 0x100,0x102,0x104, then DONE.
REQ-032 Burst arg=4, send 2 words then VLD low 1024 clocks -> O_err pulse, O_err_cnt=1, FSM back to HEAD.
REQ-033 Op 0x1010, DATA[79:64]=0x0040, arg=0x0010 -> O_c2h_addr=0x40, O_c2h_len=0x10, O_c2h_en one clock.
REQ-034 Op 0x1007 with NCH=4 -> O_err pulse, no write, O_err_cnt increments.
REQ-035 Assert I_Rst_n low during burst word 2 -> all outputs 0 immediately; next burst restarts at base 0.
